// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, turned into a single word-aligned
// memory access with byte enables, lane-replicated store data and extended load data.

module lsu_store_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,
  input  logic [1:0] off,
  input  logic [7:0] b_byte,
  input  logic [7:0] b_half,
  input  logic [7:0] b_word,
  output logic [7:0] lane_data,
  output logic       lane_be
);
  localparam logic [1:0] LIDX = LANE[1:0];

  always_comb begin
    lane_data = b_word;
    lane_be   = 1'b1;
    case (size)
      2'b00: begin lane_data = b_byte; lane_be = (off == LIDX);       end
      2'b01: begin lane_data = b_half; lane_be = (off[1] == LIDX[1]); end
      default: ;
    endcase
  end
endmodule

module load_store_unit #(
  parameter int B_WIDTH      = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_is_store,
  input  logic [2:0]           req_funct3,
  input  logic [B_WIDTH-1:0]   req_addr,
  input  logic [B_WIDTH-1:0]   req_wdata,
  input  logic [4:0]           req_rd,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [B_WIDTH-1:0]   resp_rdata,
  output logic [4:0]           resp_rd,
  output logic                 resp_exc,
  output logic [1:0]           resp_cause,
  output logic [B_WIDTH-1:0]   mem_addr,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic [B_WIDTH/8-1:0] write_byte_en,
  inout  wire  [B_WIDTH-1:0]   mem_data
);
  localparam int NB = B_WIDTH / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, RESP = 2'd3} state_t;

  state_t                 state, state_nx;
  logic                   pend;
  logic [2:0]             cnt;
  logic                   l_store;
  logic [2:0]             l_f3;
  logic [B_WIDTH-1:0]     l_addr, l_wdata;
  logic [4:0]             l_rd;
  logic                   illegal, misal, last_rd;
  logic [NB-1:0][7:0]     st_data;
  logic [NB-1:0]          st_be;
  logic [7:0]             ld_b;
  logic [15:0]            ld_h;
  logic [B_WIDTH-1:0]     ld_ext;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    lsu_store_lane #(.LANE(i)) u_lane (
      .size      (l_f3[1:0]),
      .off       (l_addr[1:0]),
      .b_byte    (l_wdata[7:0]),
      .b_half    (l_wdata[8*(i%2) +: 8]),
      .b_word    (l_wdata[8*i +: 8]),
      .lane_data (st_data[i]),
      .lane_be   (st_be[i])
    );
  end

  assign mem_data   = (state == WRITE) ? st_data : 'z;
  assign req_ready  = rst && (state == IDLE) && !pend;
  assign resp_valid = (state == RESP);
  assign last_rd    = (cnt == 3'(READ_LATENCY - 1));

  // Decode runs one cycle after accept, on the latched request.
  always_comb begin
    illegal = l_store ? (l_f3[2] || l_f3[1:0] == 2'b11)
                      : (l_f3 == 3'b011 || l_f3[2:1] == 2'b11);
    misal   = (l_f3[1:0] == 2'b01 && l_addr[0]) ||
              (l_f3[1:0] == 2'b10 && l_addr[1:0] != 2'b00);
  end

  always_comb begin
    case (l_addr[1:0])
      2'd0:    ld_b = mem_data[7:0];
      2'd1:    ld_b = mem_data[15:8];
      2'd2:    ld_b = mem_data[23:16];
      default: ld_b = mem_data[31:24];
    endcase
    ld_h = l_addr[1] ? mem_data[31:16] : mem_data[15:0];
    case (l_f3)
      3'b000:  ld_ext = {{(B_WIDTH-8){ld_b[7]}}, ld_b};
      3'b001:  ld_ext = {{(B_WIDTH-16){ld_h[15]}}, ld_h};
      3'b100:  ld_ext = {{(B_WIDTH-8){1'b0}}, ld_b};
      3'b101:  ld_ext = {{(B_WIDTH-16){1'b0}}, ld_h};
      default: ld_ext = mem_data;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (pend) state_nx = (illegal || misal) ? RESP : (l_store ? WRITE : READ);
      WRITE: state_nx = RESP;
      READ:  if (last_rd) state_nx = RESP;
      RESP:  if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      pend          <= 1'b0;
      cnt           <= '0;
      l_store       <= 1'b0;
      l_f3          <= '0;
      l_addr        <= '0;
      l_wdata       <= '0;
      l_rd          <= '0;
      resp_rdata    <= '0;
      resp_rd       <= '0;
      resp_exc      <= 1'b0;
      resp_cause    <= '0;
      mem_addr      <= '0;
      mem_read_en   <= 1'b0;
      mem_write_en  <= 1'b0;
      write_byte_en <= '0;
    end else begin
      state <= state_nx;
      pend  <= req_valid && req_ready;
      if (req_valid && req_ready) begin
        l_store <= req_is_store;
        l_f3    <= req_funct3;
        l_addr  <= req_addr;
        l_wdata <= req_wdata;
        l_rd    <= req_rd;
      end
      cnt           <= (state == READ && !last_rd) ? cnt + 3'd1 : 3'd0;
      // Strobes are registered off the next state so they line up with WRITE/READ.
      mem_read_en   <= (state_nx == READ);
      mem_write_en  <= (state_nx == WRITE);
      mem_addr      <= (state_nx == READ || state_nx == WRITE) ? {l_addr[B_WIDTH-1:2], 2'b00} : '0;
      write_byte_en <= (state_nx == WRITE) ? st_be : '0;
      if (state != RESP && state_nx == RESP) begin
        resp_rd    <= l_rd;
        resp_exc   <= (state == IDLE);
        resp_cause <= (state != IDLE) ? 2'b00 : (illegal ? 2'b10 : 2'b01);
        resp_rdata <= (state == READ) ? ld_ext : '0;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: scoreboard of expected responses, memory model
// answering reads, strobe monitor, backpressure and mid-read reset.

module tb_load_store_unit;
  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_is_store = 1'b0, resp_ready = 1'b1;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        req_ready, resp_valid, resp_exc, mem_read_en, mem_write_en;
  logic [31:0] resp_rdata, mem_addr;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_cause;
  logic [3:0]  write_byte_en;
  wire  [31:0] mem_data;
  logic [31:0] mem_word = 32'h80FF1234;

  always #5 clk = ~clk;

  assign mem_data = mem_read_en ? mem_word : 32'hz;

  load_store_unit #(.B_WIDTH(32), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_exc(resp_exc), .resp_cause(resp_cause),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .write_byte_en(write_byte_en), .mem_data(mem_data)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        exc;
    logic [1:0]  cause;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0, n_err = 0, cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
  logic [3:0]  wr_be = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_write_en) begin
      wr_cnt++; wr_addr = mem_addr; wr_be = write_byte_en; wr_data = mem_data;
    end
    if (mem_read_en) begin rd_cnt++; rd_addr = mem_addr; end
    if (mem_read_en && mem_write_en) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input logic [31:0] e_rdata, input logic e_exc, input logic [1:0] e_cause,
                        input int e_lat, input int hold, input string tag);
    int a, wc0, rc0;
    bit got;
    exp_t e;
    sb.push_back('{e_rdata, rd, e_exc, e_cause, 8'(e_lat + hold)});
    wc0 = wr_cnt; rc0 = rd_cnt;
    resp_ready = (hold == 0);
    @(negedge clk);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    a = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (resp_valid) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, " resp seen"}, 32'(got), 32'd1);
    e = sb.pop_front();
    for (int k = 0; k < hold; k++) begin
      chk({tag, " held rdata"}, resp_rdata, e.rdata);
      chk({tag, " held ready"}, 32'(req_ready), 32'd0);
      if (k == 2) begin
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h400;
      end else req_valid = 1'b0;
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    chk({tag, " valid"}, 32'(resp_valid), 32'd1);
    chk({tag, " rdata"}, resp_rdata, e.rdata);
    chk({tag, " rd"}, 32'(resp_rd), 32'(e.rd));
    chk({tag, " exc"}, 32'(resp_exc), 32'(e.exc));
    chk({tag, " cause"}, 32'(resp_cause), 32'(e.cause));
    chk({tag, " latency"}, 32'(cyc + 1 - a), 32'(e.lat));
    @(posedge clk); #1;
    chk({tag, " writes"}, 32'(wr_cnt - wc0), (st && !e_exc) ? 32'd1 : 32'd0);
    chk({tag, " reads"}, 32'(rd_cnt - rc0), (!st && !e_exc) ? 32'(RL) : 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wc, vc;
    bit seen;
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst strobes", 32'({mem_read_en, mem_write_en}), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst byte_en", 32'(write_byte_en), 32'd0);
    chk("rst cause", 32'(resp_cause), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // stores
    do_req(1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1, 32'h0, 0, 2'b00, 3, 0, "sw");
    chk("sw addr", wr_addr, 32'h100);
    chk("sw be", 32'(wr_be), 32'hF);
    chk("sw data", wr_data, 32'hDEADBEEF);
    do_req(1, 3'b000, 32'h203, 32'h000000A5, 5'd2, 32'h0, 0, 2'b00, 3, 0, "sb");
    chk("sb addr", wr_addr, 32'h200);
    chk("sb be", 32'(wr_be), 32'h8);
    chk("sb data", wr_data, 32'hA5A5A5A5);
    do_req(1, 3'b000, 32'h201, 32'h0000005A, 5'd2, 32'h0, 0, 2'b00, 3, 0, "sb1");
    chk("sb1 be", 32'(wr_be), 32'h2);
    chk("sb1 data", wr_data, 32'h5A5A5A5A);
    do_req(1, 3'b001, 32'h202, 32'h00001234, 5'd3, 32'h0, 0, 2'b00, 3, 0, "sh");
    chk("sh addr", wr_addr, 32'h200);
    chk("sh be", 32'(wr_be), 32'hC);
    chk("sh data", wr_data, 32'h12341234);

    // loads against 0x80FF1234
    do_req(0, 3'b000, 32'h303, 32'h0, 5'd4, 32'hFFFFFF80, 0, 2'b00, 2 + RL, 0, "lb");
    chk("lb addr", rd_addr, 32'h300);
    do_req(0, 3'b100, 32'h303, 32'h0, 5'd4, 32'h00000080, 0, 2'b00, 2 + RL, 0, "lbu");
    do_req(0, 3'b001, 32'h302, 32'h0, 5'd5, 32'hFFFF80FF, 0, 2'b00, 2 + RL, 0, "lh");
    do_req(0, 3'b101, 32'h302, 32'h0, 5'd5, 32'h000080FF, 0, 2'b00, 2 + RL, 0, "lhu");
    do_req(0, 3'b010, 32'h300, 32'h0, 5'd7, 32'h80FF1234, 0, 2'b00, 2 + RL, 0, "lw");
    do_req(0, 3'b000, 32'h300, 32'h0, 5'd6, 32'h00000034, 0, 2'b00, 2 + RL, 0, "lb0");
    do_req(0, 3'b001, 32'h300, 32'h0, 5'd6, 32'h00001234, 0, 2'b00, 2 + RL, 0, "lh0");

    // faults
    do_req(0, 3'b010, 32'h102, 32'h0, 5'd8, 32'h0, 1, 2'b01, 2, 0, "lw mis");
    do_req(0, 3'b001, 32'h301, 32'h0, 5'd8, 32'h0, 1, 2'b01, 2, 0, "lh mis");
    do_req(1, 3'b001, 32'h203, 32'h0, 5'd8, 32'h0, 1, 2'b01, 2, 0, "sh mis");
    do_req(0, 3'b011, 32'h300, 32'h0, 5'd9, 32'h0, 1, 2'b10, 2, 0, "ld f3 011");
    do_req(0, 3'b110, 32'h300, 32'h0, 5'd9, 32'h0, 1, 2'b10, 2, 0, "ld f3 110");
    do_req(1, 3'b100, 32'h101, 32'h0, 5'd9, 32'h0, 1, 2'b10, 2, 0, "st f3 100");

    // backpressure with a request pulse during RESP
    do_req(0, 3'b010, 32'h300, 32'h0, 5'd9, 32'h80FF1234, 0, 2'b00, 2 + RL, 5, "bp");
    wc = wr_cnt; vc = 0;
    repeat (4) begin @(negedge clk); if (resp_valid) vc++; end
    chk("bp no accept writes", 32'(wr_cnt - wc), 32'd0);
    chk("bp no accept resp", 32'(vc), 32'd0);

    // reset in the middle of a read, after a fault left resp fields non-zero
    do_req(1, 3'b111, 32'h100, 32'h0, 5'd11, 32'h0, 1, 2'b10, 2, 0, "st f3 111");
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300; req_rd = 5'd3;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (mem_read_en) seen = 1'b1;
      else @(negedge clk);
    end
    chk("mid read started", 32'(seen), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst req_ready", 32'(req_ready), 32'd0);
    chk("arst resp_valid", 32'(resp_valid), 32'd0);
    chk("arst strobes", 32'({mem_read_en, mem_write_en}), 32'd0);
    chk("arst mem_addr", mem_addr, 32'd0);
    chk("arst byte_en", 32'(write_byte_en), 32'd0);
    chk("arst resp_rd", 32'(resp_rd), 32'd0);
    chk("arst exc/cause", 32'({resp_exc, resp_cause}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    vc = 0;
    repeat (6) begin @(negedge clk); if (resp_valid) vc++; end
    chk("arst no resp", 32'(vc), 32'd0);
    mem_word = 32'h13579BDF;
    do_req(0, 3'b010, 32'h304, 32'h0, 5'd7, 32'h13579BDF, 0, 2'b00, 2 + RL, 0, "lw post");
    chk("lw post addr", rd_addr, 32'h304);
    chk("strobe overlap", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
